pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/bbtron_pkg.sv | 16 +
 rtl/pc_stack.sv | 59 +++++
 rtl/pc_sequencer.sv | 146 ++++++++++++++
 tb/tb_pc_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bbtron_pkg.sv
// Shared FSM state and jump-select encodings for the PC sequencer.
// Pure declarations; no latency and no flow control involved.
package bbtron_pkg;

  typedef enum logic [1:0] {
    STEP_WAIT = 2'd0,
    RUN       = 2'd1,
    HALT      = 2'd2
  } state_e;

  localparam logic [1:0] JS_SEQ    = 2'b00;
  localparam logic [1:0] JS_BRANCH = 2'b01;
  localparam logic [1:0] JS_ABS    = 2'b10;
  localparam logic [1:0] JS_REG    = 2'b11;

endpackage

// File: rtl/pc_stack.sv
// Return-address LIFO: push/pop take effect at the clock edge, top/count/full/empty are registered-state views.
// No backpressure: push while full and pop while empty are ignored; the caller flags those cases.
module pc_stack #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [DATA_W-1:0]            data_i,
  output logic [DATA_W-1:0]            top_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o & ~push_i;
  assign wr_idx  = IDX_W'(count_q);
  assign rd_idx  = IDX_W'(count_q - CNT_W'(1));
  assign top_o   = mem_q[rd_idx];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Entries are left stale on reset; an empty count makes them unreachable.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_idx] <= data_i;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer with run/step/halt control and a call/return stack.
// Next PC commits on the edge ending an advance cycle; halt freezes the PC until resume.
module pc_sequencer
  import bbtron_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter int                STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             run_mode_i,
  input  logic                             step_btn_i,
  input  logic                             hlt_i,
  input  logic                             resume_i,
  input  logic [1:0]                       jump_sel_i,
  input  logic                             branch_taken_i,
  input  logic                             call_i,
  input  logic                             ret_i,
  input  logic [ADDR_W-1:0]                imm_i,
  input  logic [ADDR_W-1:0]                target_i,
  input  logic [ADDR_W-1:0]                reg_target_i,
  output logic [ADDR_W-1:0]                pc_o,
  output logic                             advance_o,
  output logic [1:0]                       state_o,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_count_o,
  output logic                             stack_overflow_o,
  output logic                             stack_underflow_o
);

  state_e            state_q, state_d;
  logic              step_q;
  logic              step_edge;
  logic              advance;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              push, pop;
  logic [ADDR_W-1:0] stack_top;
  logic              stack_full, stack_empty;

  assign step_edge = step_btn_i & ~step_q;
  assign pc_inc    = pc_q + ADDR_W'(1);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= STEP_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      STEP_WAIT: begin
        if (advance && hlt_i)  state_d = HALT;
        else if (run_mode_i)   state_d = RUN;
      end
      RUN: begin
        if (hlt_i)             state_d = HALT;
        else if (!run_mode_i)  state_d = STEP_WAIT;
      end
      HALT: begin
        if (resume_i)          state_d = run_mode_i ? RUN : STEP_WAIT;
      end
      default:                 state_d = STEP_WAIT;
    endcase
  end

  always_comb begin
    advance = 1'b0;
    case (state_q)
      RUN:       advance = 1'b1;
      STEP_WAIT: advance = step_edge;
      default:   advance = 1'b0;
    endcase
  end

  // Return beats call beats jump_sel; a halting instruction commits nothing.
  always_comb begin
    pc_d  = pc_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    push  = 1'b0;
    pop   = 1'b0;
    if (advance && !hlt_i) begin
      if (ret_i) begin
        if (stack_empty) begin
          pc_d  = pc_inc;
          udf_d = 1'b1;
        end else begin
          pc_d = stack_top;
          pop  = 1'b1;
        end
      end else if (call_i) begin
        pc_d = target_i;
        if (stack_full) ovf_d = 1'b1;
        else            push  = 1'b1;
      end else begin
        case (jump_sel_i)
          JS_SEQ:    pc_d = pc_inc;
          JS_BRANCH: pc_d = branch_taken_i ? (pc_inc + imm_i) : pc_inc;
          JS_ABS:    pc_d = target_i;
          JS_REG:    pc_d = reg_target_i;
          default:   pc_d = pc_inc;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_q   <= RESET_PC;
      step_q <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      step_q <= step_btn_i;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  pc_stack #(
    .DATA_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (pc_inc),
    .top_o   (stack_top),
    .count_o (stack_count_o),
    .full_o  (stack_full),
    .empty_o (stack_empty)
  );

  assign pc_o              = pc_q;
  assign advance_o         = advance;
  assign state_o           = state_q;
  assign stack_overflow_o  = ovf_q;
  assign stack_underflow_o = udf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a depth-2 instance is the main target, a depth-4 twin on the same inputs covers deeper fills.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_mode, step_btn, hlt, resume, branch_taken, call, ret;
  logic [1:0]  jump_sel;
  logic [15:0] imm, target, reg_target;

  logic [15:0] a_pc, b_pc;
  logic        a_adv, b_adv;
  logic [1:0]  a_state, b_state;
  logic [1:0]  a_cnt;
  logic [2:0]  b_cnt;
  logic        a_ovf, a_udf, b_ovf, b_udf;

  int vectors = 0;
  int miscompares = 0;
  int pulses;

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(16), .STACK_DEPTH(2), .RESET_PC(16'h0000)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .run_mode_i(run_mode), .step_btn_i(step_btn),
    .hlt_i(hlt), .resume_i(resume), .jump_sel_i(jump_sel), .branch_taken_i(branch_taken),
    .call_i(call), .ret_i(ret), .imm_i(imm), .target_i(target), .reg_target_i(reg_target),
    .pc_o(a_pc), .advance_o(a_adv), .state_o(a_state), .stack_count_o(a_cnt),
    .stack_overflow_o(a_ovf), .stack_underflow_o(a_udf)
  );

  pc_sequencer #(.ADDR_W(16), .STACK_DEPTH(4), .RESET_PC(16'h0000)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .run_mode_i(run_mode), .step_btn_i(step_btn),
    .hlt_i(hlt), .resume_i(resume), .jump_sel_i(jump_sel), .branch_taken_i(branch_taken),
    .call_i(call), .ret_i(ret), .imm_i(imm), .target_i(target), .reg_target_i(reg_target),
    .pc_o(b_pc), .advance_o(b_adv), .state_o(b_state), .stack_count_o(b_cnt),
    .stack_overflow_o(b_ovf), .stack_underflow_o(b_udf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic pulse();
    step_btn = 1'b1;
    tick();
    step_btn = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; run_mode = 1'b0; step_btn = 1'b0; hlt = 1'b0; resume = 1'b0;
    branch_taken = 1'b0; call = 1'b0; ret = 1'b0; jump_sel = 2'b00;
    imm = '0; target = '0; reg_target = '0;

    #3;
    chk("rst_pc", a_pc, 32'h0);
    chk("rst_state", a_state, 32'd0);
    chk("rst_cnt", a_cnt, 32'd0);
    chk("rst_ovf", a_ovf, 32'd0);
    chk("rst_udf", a_udf, 32'd0);
    chk("rst_adv", a_adv, 32'd0);
    tick(); tick();
    rst_n = 1'b1;

    // Free run: one edge to enter RUN, then pc counts 0,1,2,3
    run_mode = 1'b1;
    tick();
    chk("run_state", a_state, 32'd1);
    chk("run_pc0", a_pc, 32'h0);
    settle();
    chk("run_adv0", a_adv, 32'd1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("run_pc", a_pc, i);
      chk("run_adv", a_adv, 32'd1);
    end

    // Single step with the button held for five cycles
    rst_n = 1'b0;
    settle();
    chk("rst2_pc", a_pc, 32'h0);
    chk("rst2_state", a_state, 32'd0);
    run_mode = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    step_btn = 1'b1;
    settle();
    chk("step_edge_adv", a_adv, 32'd1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (a_adv) pulses++;
      tick();
    end
    chk("step_pulses", pulses, 32'd1);
    chk("step_pc", a_pc, 32'h1);
    chk("step_state", a_state, 32'd0);
    step_btn = 1'b0;
    tick();

    // Branch, wrap and jump forms
    jump_sel = 2'b10; target = 16'h0010; pulse();
    chk("abs_pc", a_pc, 32'h0010);
    jump_sel = 2'b01; imm = 16'hFFFC; branch_taken = 1'b1; pulse();
    chk("br_taken_pc", a_pc, 32'h000D);
    branch_taken = 1'b0; pulse();
    chk("br_not_taken_pc", a_pc, 32'h000E);
    jump_sel = 2'b10; target = 16'hFFFF; pulse();
    chk("abs_ffff", a_pc, 32'hFFFF);
    jump_sel = 2'b00; pulse();
    chk("wrap_pc", a_pc, 32'h0000);
    jump_sel = 2'b11; reg_target = 16'h1234; pulse();
    chk("jreg_pc", a_pc, 32'h1234);

    // Calls past the depth-2 limit, then returns past empty
    jump_sel = 2'b10; target = 16'h0005; pulse();
    chk("pc5", a_pc, 32'h0005);
    jump_sel = 2'b00; call = 1'b1;
    target = 16'h0020; pulse();
    chk("call1_pc", a_pc, 32'h0020);
    chk("call1_cnt", a_cnt, 32'd1);
    target = 16'h0040; pulse();
    chk("call2_pc", a_pc, 32'h0040);
    chk("call2_cnt", a_cnt, 32'd2);
    chk("call2_ovf", a_ovf, 32'd0);
    target = 16'h0060; pulse();
    chk("call3_pc", a_pc, 32'h0060);
    chk("call3_cnt", a_cnt, 32'd2);
    chk("call3_ovf", a_ovf, 32'd1);
    chk("b_call3_cnt", b_cnt, 32'd3);
    chk("b_call3_ovf", b_ovf, 32'd0);
    call = 1'b0; ret = 1'b1;
    pulse();
    chk("ret1_pc", a_pc, 32'h0021);
    chk("ret1_cnt", a_cnt, 32'd1);
    pulse();
    chk("ret2_pc", a_pc, 32'h0006);
    chk("ret2_cnt", a_cnt, 32'd0);
    chk("ret2_udf", a_udf, 32'd0);
    pulse();
    chk("ret3_pc", a_pc, 32'h0007);
    chk("ret3_udf", a_udf, 32'd1);
    chk("ret3_cnt", a_cnt, 32'd0);
    call = 1'b1; pulse();
    chk("callret_pc", a_pc, 32'h0008);
    chk("callret_cnt", a_cnt, 32'd0);
    chk("ovf_sticky", a_ovf, 32'd1);
    call = 1'b0; ret = 1'b0;

    // Halt at pc=7, hold for ten cycles, resume and re-present
    rst_n = 1'b0;
    settle();
    chk("rst3_ovf", a_ovf, 32'd0);
    chk("rst3_udf", a_udf, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    jump_sel = 2'b10; target = 16'h0007; pulse();
    jump_sel = 2'b00;
    chk("pc7", a_pc, 32'h0007);
    run_mode = 1'b1;
    tick();
    chk("pre_hlt_state", a_state, 32'd1);
    hlt = 1'b1;
    settle();
    chk("hlt_adv", a_adv, 32'd1);
    tick();
    hlt = 1'b0;
    settle();
    chk("halt_state", a_state, 32'd2);
    for (int i = 0; i < 10; i++) begin
      chk("halt_adv", a_adv, 32'd0);
      chk("halt_pc", a_pc, 32'h0007);
      chk("halt_hold", a_state, 32'd2);
      tick();
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("resume_state", a_state, 32'd1);
    chk("resume_pc", a_pc, 32'h0007);
    settle();
    chk("resume_adv", a_adv, 32'd1);
    hlt = 1'b1;
    tick();
    hlt = 1'b0;
    chk("rehalt_state", a_state, 32'd2);
    chk("rehalt_pc", a_pc, 32'h0007);
    run_mode = 1'b0; resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("resume_step_state", a_state, 32'd0);
    chk("resume_step_pc", a_pc, 32'h0007);

    // Asynchronous reset in RUN with three stacked entries
    run_mode = 1'b1;
    tick();
    chk("run2_state", a_state, 32'd1);
    call = 1'b1; target = 16'h0100;
    tick(); tick(); tick();
    call = 1'b0;
    chk("b_fill_cnt", b_cnt, 32'd3);
    chk("fill_pc", a_pc, 32'h0100);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_pc", a_pc, 32'h0);
    chk("arst_state", a_state, 32'd0);
    chk("arst_cnt", a_cnt, 32'd0);
    chk("b_arst_cnt", b_cnt, 32'd0);
    chk("b_arst_pc", b_pc, 32'h0);
    chk("arst_adv", a_adv, 32'd0);
    chk("arst_ovf", a_ovf, 32'd0);
    run_mode = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    ret = 1'b1; pulse(); ret = 1'b0;
    chk("post_rst_ret_pc", a_pc, 32'h0001);
    chk("post_rst_ret_udf", a_udf, 32'd1);
    chk("b_post_rst_ret_pc", b_pc, 32'h0001);
    chk("b_post_rst_ret_udf", b_udf, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
